// File: rtl/system_0_sysid_checker.sv
// system_0_sysid_checker
// Reads the two words of a sysid slave (ID, then build timestamp), compares
// them against the values this build was generated with and reports the
// result. A check runs on request through start, and optionally once on its
// own after reset. Failed checks are counted with an 8-bit saturating counter.

module system_0_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1563220165,
   parameter int          READ_LATENCY       = 0,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        pass,
   output logic [7:0]  mismatch_count
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ID   = 3'd1,
      WAIT_ID = 3'd2,
      RD_TS   = 3'd3,
      WAIT_TS = 3'd4,
      DONE    = 3'd5
   } stateT;

   // A latency of zero means the data is valid in the read cycle itself, so
   // the wait states are never visited. Otherwise the wait counter is loaded
   // with latency-1 and the capture happens when it reaches zero.
   localparam bit        hasWait  = (READ_LATENCY != 0);
   localparam logic [1:0] waitLoad = 2'(hasWait ? READ_LATENCY - 1 : 0);

   stateT      state;
   stateT      nextState;
   logic [1:0] waitCnt;
   logic       autoPending;
   logic       launch;
   logic       captureId;
   logic       captureTs;

   // Decide when a sequence is launched and when the slave data is taken.
   // The pending auto-start flag behaves exactly like a held start input,
   // but only while idle, so requests arriving during a sequence are dropped.
   always_comb begin
      launch    = (state == IDLE) && (start || autoPending);
      captureId = ((state == RD_ID) && !hasWait) ||
                  ((state == WAIT_ID) && (waitCnt == 2'd0));
      captureTs = ((state == RD_TS) && !hasWait) ||
                  ((state == WAIT_TS) && (waitCnt == 2'd0));
   end

   // Next-state logic for the read sequence. Each read state lasts one cycle;
   // wait states hold until the latency counter has run out.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (launch) nextState = RD_ID;
         RD_ID:   nextState = hasWait ? WAIT_ID : RD_TS;
         WAIT_ID: if (waitCnt == 2'd0) nextState = RD_TS;
         RD_TS:   nextState = hasWait ? WAIT_TS : DONE;
         WAIT_TS: if (waitCnt == 2'd0) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // State register; reset abandons any sequence in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Latency counter: loaded on every read cycle, counted down in the
   // following wait state. It is idle at zero everywhere else.
   always_ff @(posedge clock) begin
      if (reset) begin
         waitCnt <= 2'd0;
      end else if ((state == RD_ID) || (state == RD_TS)) begin
         waitCnt <= waitLoad;
      end else if (waitCnt != 2'd0) begin
         waitCnt <= waitCnt - 2'd1;
      end
   end

   // Word select towards the slave. It switches to the timestamp word at the
   // same edge the ID is captured (which is also the edge entering RD_TS),
   // and otherwise keeps its last value so the slave sees a stable address
   // through the wait states and afterwards.
   always_ff @(posedge clock) begin
      if (reset) begin
         sysid_address <= 1'b0;
      end else if (launch) begin
         sysid_address <= 1'b0;
      end else if (captureId) begin
         sysid_address <= 1'b1;
      end
   end

   // The auto-start request is armed only by reset and consumed by the first
   // sequence, so it can fire at most once per reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         autoPending <= AUTO_START;
      end else if (launch) begin
         autoPending <= 1'b0;
      end
   end

   // Captured words and verdict flags. They are cleared when a new sequence
   // starts and otherwise hold, so the result of the last check stays
   // readable until the next one. pass is formed at the timestamp capture
   // so it is already valid during the DONE cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         id_value <= 32'd0;
         ts_value <= 32'd0;
         id_ok    <= 1'b0;
         ts_ok    <= 1'b0;
         pass     <= 1'b0;
      end else if (launch) begin
         id_ok <= 1'b0;
         ts_ok <= 1'b0;
         pass  <= 1'b0;
      end else if (captureId) begin
         id_value <= sysid_readdata;
         id_ok    <= (sysid_readdata == EXPECTED_ID);
      end else if (captureTs) begin
         ts_value <= sysid_readdata;
         ts_ok    <= (sysid_readdata == EXPECTED_TIMESTAMP);
         pass     <= id_ok && (sysid_readdata == EXPECTED_TIMESTAMP);
      end
   end

   // Failure counter: bumped once per completed failing check at the end of
   // the DONE cycle, and pinned at 255 rather than wrapping back to zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         mismatch_count <= 8'd0;
      end else if ((state == DONE) && !pass && (mismatch_count != 8'hFF)) begin
         mismatch_count <= mismatch_count + 8'd1;
      end
   end

   // Status and strobe outputs follow directly from the state, which keeps
   // the read strobe confined to the two read states by construction.
   always_comb begin
      sysid_read = (state == RD_ID) || (state == RD_TS);
      busy       = (state != IDLE);
      done       = (state == DONE);
   end

endmodule

// File: tb/tb_system_0_sysid_checker.sv
// tb_system_0_sysid_checker
// Three checker instances share one clock and reset:
//   A: latency 0, no auto-start, slave timestamp adjustable from the bench
//   B: latency 2, no auto-start, slave data valid only in the capture cycle
//   C: latency 1, auto-start, used for the auto-start and mid-sequence reset
// Each slave model drives a junk word whenever its data is not meant to be
// sampled, so a capture in the wrong cycle shows up as a wrong value.

module tb_system_0_sysid_checker;

   localparam logic [31:0] ID    = 32'd0;
   localparam logic [31:0] TS    = 32'd1563220165;
   localparam logic [31:0] JUNK  = 32'hDEADBEEF;

   logic clock = 1'b0;
   logic reset = 1'b1;

   logic        startA = 1'b0, readA, addrA, busyA, doneA, idOkA, tsOkA, passA;
   logic [31:0] rdataA, idValA, tsValA;
   logic [7:0]  mcA;
   logic [31:0] tsA = TS;

   logic        startB = 1'b0, readB, addrB, busyB, doneB, idOkB, tsOkB, passB;
   logic [31:0] rdataB, idValB, tsValB;
   logic [7:0]  mcB;
   logic [1:0]  rdPipeB = 2'b00, adPipeB = 2'b00;

   logic        startC = 1'b0, readC, addrC, busyC, doneC, idOkC, tsOkC, passC;
   logic [31:0] rdataC, idValC, tsValC;
   logic [7:0]  mcC;
   logic        rdPipeC = 1'b0, adPipeC = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   system_0_sysid_checker #(
      .EXPECTED_ID(ID), .EXPECTED_TIMESTAMP(TS), .READ_LATENCY(0), .AUTO_START(1'b0)
   ) dutA (
      .clock(clock), .reset(reset), .start(startA),
      .sysid_address(addrA), .sysid_read(readA), .sysid_readdata(rdataA),
      .id_value(idValA), .ts_value(tsValA), .busy(busyA), .done(doneA),
      .id_ok(idOkA), .ts_ok(tsOkA), .pass(passA), .mismatch_count(mcA)
   );

   system_0_sysid_checker #(
      .EXPECTED_ID(ID), .EXPECTED_TIMESTAMP(TS), .READ_LATENCY(2), .AUTO_START(1'b0)
   ) dutB (
      .clock(clock), .reset(reset), .start(startB),
      .sysid_address(addrB), .sysid_read(readB), .sysid_readdata(rdataB),
      .id_value(idValB), .ts_value(tsValB), .busy(busyB), .done(doneB),
      .id_ok(idOkB), .ts_ok(tsOkB), .pass(passB), .mismatch_count(mcB)
   );

   system_0_sysid_checker #(
      .EXPECTED_ID(ID), .EXPECTED_TIMESTAMP(TS), .READ_LATENCY(1), .AUTO_START(1'b1)
   ) dutC (
      .clock(clock), .reset(reset), .start(startC),
      .sysid_address(addrC), .sysid_read(readC), .sysid_readdata(rdataC),
      .id_value(idValC), .ts_value(tsValC), .busy(busyC), .done(doneC),
      .id_ok(idOkC), .ts_ok(tsOkC), .pass(passC), .mismatch_count(mcC)
   );

   // Slave A answers in the read cycle itself.
   assign rdataA = readA ? (addrA ? tsA : ID) : JUNK;

   // Slaves B and C delay the read strobe and address by their latency and
   // only present real data in the cycle the checker should sample.
   always @(posedge clock) begin
      if (reset) begin
         rdPipeB <= 2'b00;
         adPipeB <= 2'b00;
         rdPipeC <= 1'b0;
         adPipeC <= 1'b0;
      end else begin
         rdPipeB <= {rdPipeB[0], readB};
         adPipeB <= {adPipeB[0], addrB};
         rdPipeC <= readC;
         adPipeC <= addrC;
      end
   end

   assign rdataB = rdPipeB[1] ? (adPipeB[1] ? TS : ID) : JUNK;
   assign rdataC = rdPipeC ? (adPipeC ? TS : ID) : JUNK;

   // Hard stop in case something never returns.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic       start;
      logic [4:0] expOut;
   } vecT;

   vecT vecs[5];

   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic startValue);
      startA = startValue;
      stepCycle();
   endtask

   // One checker-A sequence from a start pulse; returns {id_ok, ts_ok, pass}
   // seen during done and leaves the bench in the idle cycle after done.
   task automatic runSeqA(output logic [2:0] okBits);
      logic found;
      found  = 1'b0;
      okBits = 3'b000;
      applyStimulus(1'b1);
      startA = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         if (doneA) begin
            found  = 1'b1;
            okBits = {idOkA, tsOkA, passA};
         end else begin
            stepCycle();
         end
      end
      checkOutput("seqA_done_seen", {127'd0, found}, 128'd1);
      stepCycle();
   endtask

   function automatic logic [78:0] allC();
      return {readC, addrC, busyC, doneC, idOkC, tsOkC, passC, mcC, idValC, tsValC};
   endfunction

   initial begin
      logic [2:0]  ok;
      logic [31:0] readMask;
      logic [31:0] doneMask;
      logic        passAt7;

      vecs[0] = '{1'b1, 5'b10100};
      vecs[1] = '{1'b0, 5'b11100};
      vecs[2] = '{1'b1, 5'b01111};
      vecs[3] = '{1'b1, 5'b01001};
      vecs[4] = '{1'b0, 5'b01001};

      // Reset values on every instance.
      stepCycle();
      stepCycle();
      checkOutput("resetA", {readA, addrA, busyA, doneA, idOkA, tsOkA, passA, mcA, idValA, tsValA}, 128'd0);
      checkOutput("resetB", {readB, addrB, busyB, doneB, idOkB, tsOkB, passB, mcB, idValB, tsValB}, 128'd0);
      checkOutput("resetC", allC(), 128'd0);

      // Release reset: C starts on its own, A stays idle.
      reset = 1'b0;
      stepCycle();
      checkOutput("autoC_rdId", {readC, addrC, busyC}, 3'b101);
      checkOutput("noAutoA", busyA, 1'b0);
      stepCycle();
      stepCycle();
      stepCycle();
      checkOutput("autoC_waitTs", {readC, addrC, busyC, doneC}, 4'b0110);
      stepCycle();
      checkOutput("autoC_done", {doneC, passC, idOkC, tsOkC}, 4'b1111);
      checkOutput("autoC_tsValue", tsValC, TS);
      stepCycle();
      checkOutput("autoC_idle", {busyC, mcC}, 9'd0);

      // Table: latency-0 sequence, including a start ignored in DONE.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].start);
         checkOutput($sformatf("tableA_row%0d", i), {readA, addrA, busyA, doneA, passA}, vecs[i].expOut);
      end
      startA = 1'b0;
      checkOutput("tableA_idValue", idValA, ID);
      checkOutput("tableA_tsValue", tsValA, TS);
      checkOutput("tableA_oks_mc", {idOkA, tsOkA, mcA}, {2'b11, 8'd0});

      // Latency 2: strobes in cycles 1 and 4, done in cycle 7.
      readMask = 32'd0;
      doneMask = 32'd0;
      passAt7  = 1'b0;
      startB = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         stepCycle();
         if (k == 1) startB = 1'b0;
         readMask[k] = readB;
         doneMask[k] = doneB;
         if (k == 7) passAt7 = passB;
      end
      checkOutput("B_readCycles", readMask, 32'h0000_0012);
      checkOutput("B_doneCycle", doneMask, 32'h0000_0080);
      checkOutput("B_pass", passAt7, 1'b1);
      checkOutput("B_values", {idValB, tsValB, mcB}, {ID, TS, 8'd0});

      // Wrong timestamp: one failed check.
      tsA = TS + 32'd1;
      runSeqA(ok);
      checkOutput("A_badTs_oks", ok, 3'b100);
      checkOutput("A_badTs_count", mcA, 8'd1);
      checkOutput("A_badTs_tsValue", tsValA, TS + 32'd1);

      // Start held for 20 cycles: a sequence every 4 cycles.
      tsA = TS;
      readMask = 32'd0;
      doneMask = 32'd0;
      startA = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         stepCycle();
         readMask[k] = readA;
         doneMask[k] = doneA;
      end
      startA = 1'b0;
      checkOutput("A_b2b_reads", readMask, 32'h0006_6666);
      checkOutput("A_b2b_dones", doneMask, 32'h0008_8888);
      checkOutput("A_b2b_count", mcA, 8'd1);
      stepCycle();

      // 300 failing checks: counter saturates at 255.
      tsA = TS + 32'd1;
      for (int n = 1; n <= 300; n++) begin
         runSeqA(ok);
         if (n == 253) checkOutput("A_sat_254", mcA, 8'd254);
         if (n == 254) checkOutput("A_sat_255", mcA, 8'd255);
      end
      checkOutput("A_sat_hold", mcA, 8'd255);
      tsA = TS;

      // Reset while C sits in WAIT_TS.
      startC = 1'b1;
      stepCycle();
      startC = 1'b0;
      stepCycle();
      stepCycle();
      stepCycle();
      checkOutput("C_inWaitTs", {readC, addrC, busyC, doneC}, 4'b0110);
      reset = 1'b1;
      stepCycle();
      checkOutput("C_abortReset", allC(), 128'd0);
      checkOutput("A_countReset", mcA, 8'd0);
      stepCycle();
      checkOutput("C_noDone", allC(), 128'd0);
      reset = 1'b0;
      stepCycle();
      checkOutput("C_autoAfterReset", {readC, addrC, busyC}, 3'b101);
      stepCycle();
      stepCycle();
      stepCycle();
      stepCycle();
      checkOutput("C_autoDone", {doneC, passC, mcC}, {2'b11, 8'd0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
